lab_dp: RTL and testbench
=========================

# lab_dp

Datapath for the 8-bit accumulator CPU. It executes the control word issued each cycle by the control unit: memory address select, IR/PC/A loads, ALU add or subtract, memory write. It returns opcode and accumulator status to the control unit. It contains PC, IR, accumulator A, the ALU, and a 32x8 synchronous-read program/data RAM with a host preload port.

## Interface
Parameters:
- DW, 8: data / accumulator / IR width
- AW, 5: address width (RAM depth 2^AW)

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- IRload  in  1  load IR from RAM read data
- JMPmux  in  1  PC source: 0 = PC+1, 1 = IR[AW-1:0]
- PCload  in  1  load PC from the selected source
- Meminst  in  1  RAM address: 0 = PC, 1 = IR[AW-1:0]
- MemWr  in  1  write A to RAM at the selected address
- Asel  in  2  A source: 00 = ALU, 01 = switches, 10 = RAM read data, 11 = zero
- Aload  in  1  load A from the Asel source
- Sub  in  1  ALU op: 0 = A+M, 1 = A−M
- switches  in  DW  user input value
- load_en  in  1  host preload write strobe
- load_addr  in  AW  host preload address
- load_data  in  DW  host preload data
- IR  out  3  opcode, IR[DW-1:DW-3]
- Aeq0  out  1  A == 0
- Apos  out  1  A[DW-1] == 0 (non-negative)
- A_out  out  DW  accumulator value
- PC_out  out  AW  program counter value

## Operation
- Instruction format: IR[7:5] opcode, IR[4:0] operand address.
- RAM address mux: addr = Meminst ? IR[4:0] : PC.
- RAM read is synchronous: a registered read-data word M is updated every edge with mem[addr]. The data for the address presented in cycle n is valid in cycle n+1.
- This one-cycle latency is required. The control unit presents the PC address one state before IRload, and the IR address one state before the LOAD/ADD/SUB state.
- Write: when MemWr=1, mem[addr] <= A at the edge. Read-during-write on the same address returns the old data.
- Preload: when load_en=1, mem[load_addr] <= load_data. This takes priority over MemWr in the same cycle; the MemWr write is dropped.
- IR: when IRload=1, IR register <= M.
- PC: when PCload=1, PC <= JMPmux ? IR[4:0] : PC+1. PC+1 wraps 31→0.
- ALU: R = Sub ? A−M : A+M, modulo 2^DW. No carry or overflow flag.
- A: when Aload=1, A <= the source selected by Asel.
- Aeq0 and Apos are combinational from the A register. They are not derived from R.
- IR output is combinational from the IR register.
- Simultaneous loads of IR, PC and A in one cycle are all honoured. Every load uses pre-edge values; for example, IRload with PCload+JMPmux jumps to the old IR address.

## Timing
- Reset (asynchronous assert, synchronous to clock on release) sets: PC=0, IR register=0, A=0, M=0.
- Resulting outputs after reset: IR=000, Aeq0=1, Apos=1, A_out=0, PC_out=0.
- RAM contents are not cleared by reset. A preload performed during or before reset persists.
- Reset asserted mid-instruction clears the registers immediately. A RAM write is committed only if its edge occurred before reset asserted.
- Register latency: one edge from control assertion to register update.
- RAM read latency: one edge from address to M.
- Status latency: Aeq0/Apos reflect the new A value in the same cycle A_out changes.
- The preload port is usable in any cycle, including while reset is low.

## Structure
- Shared package (lab_pkg): DW and AW, opcode constants (LOAD=000, STORE=001, ADD=010, SUB=011, IN=100, JZ=101, JPOS=110, HALT=111), and Asel encodings (ASEL_ALU, ASEL_SW, ASEL_MEM, ASEL_ZERO).
- Sub-module lab_ram: a 2^AW x DW single-port RAM with synchronous read, one write port driven by the muxed address/data, and preload priority inside it.
- Registers, muxes and ALU stay in lab_dp.

## Test plan
- Reset: preload mem[0]=8'h3F, hold reset low, release → PC_out=0, A_out=0, Aeq0=1, Apos=1, IR=000, mem[0] still 8'h3F.
- Fetch: mem[0]=8'h45. Cycle 0 with Meminst=0, cycle 1 with IRload=1 and PCload=1, JMPmux=0 → IR=010, PC_out=1.
- ALU wrap: A=8'hF0, mem[5]=8'h20. Meminst=1 for one cycle, then Aload with Asel=00, Sub=0 → A_out=8'h10. Repeat with Sub=1 from A=8'h10 and M=8'h20 → A_out=8'hF0, Apos=0, Aeq0=0.
- Store/load: A=8'h7A. Meminst=1, MemWr=1 at IR addr 9 → mem[9]=8'h7A. Then A cleared via Asel=11, then a LOAD sequence (Meminst=1 cycle, then Asel=10 with Aload) → A_out=8'h7A.
- Jump and wrap: IR register = 8'hB7 with JMPmux=1, PCload=1 → PC_out=23. From PC=31, an increment → PC_out=0.
- Collision: load_en=1 and MemWr=1 both targeting addr 3 in the same cycle → mem[3]=load_data. IN with switches=8'h81 → A_out=8'h81, Apos=0.

Source files
------------

// File: rtl/lab_pkg.sv
// Shared definitions for the accumulator CPU: widths, opcode encoding and
// accumulator source select encoding.
package lab_pkg;

    localparam int DW = 8;
    localparam int AW = 5;

    // Instruction opcodes carried in IR[7:5].
    typedef enum logic [2:0] {
        LOAD  = 3'b000,
        STORE = 3'b001,
        ADD   = 3'b010,
        SUB   = 3'b011,
        IN    = 3'b100,
        JZ    = 3'b101,
        JPOS  = 3'b110,
        HALT  = 3'b111
    } opcode_e;

    // Accumulator source select.
    typedef enum logic [1:0] {
        ASEL_ALU  = 2'b00,
        ASEL_SW   = 2'b01,
        ASEL_MEM  = 2'b10,
        ASEL_ZERO = 2'b11
    } asel_e;

endpackage

// File: rtl/lab_dp_if.sv
// Control-word / status / preload bundle between the control unit (master)
// and the datapath (slave). The host preload port rides along with it.
interface lab_dp_if
    import lab_pkg::*;
#(
    parameter int DW = lab_pkg::DW,
    parameter int AW = lab_pkg::AW
);

    // Control word issued by the control unit every cycle
    logic          IRload;
    logic          JMPmux;
    logic          PCload;
    logic          Meminst;
    logic          MemWr;
    logic [1:0]    Asel;
    logic          Aload;
    logic          Sub;
    logic [DW-1:0] switches;

    // Host preload port
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;

    // Status and observation back from the datapath
    logic [2:0]    IR;
    logic          Aeq0;
    logic          Apos;
    logic [DW-1:0] A_out;
    logic [AW-1:0] PC_out;

    modport master (
        output IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub,
        output switches, load_en, load_addr, load_data,
        input  IR, Aeq0, Apos, A_out, PC_out
    );

    modport slave (
        input  IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub,
        input  switches, load_en, load_addr, load_data,
        output IR, Aeq0, Apos, A_out, PC_out
    );

endinterface

// File: rtl/lab_ram.sv
// 2^AW x DW single-port program/data RAM with a registered (synchronous) read
// word and a host preload path that wins over the datapath write.
// The array itself is never reset so preloaded programs survive reset.
module lab_ram
    import lab_pkg::*;
#(
    parameter int DW = lab_pkg::DW,
    parameter int AW = lab_pkg::AW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          we_i,
    input  logic          load_en_i,
    input  logic [AW-1:0] load_addr_i,
    input  logic [DW-1:0] load_data_i,
    output logic [DW-1:0] rdata_o
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    logic          wr_en_d;
    logic [AW-1:0] wr_addr_d;
    logic [DW-1:0] wr_data_d;

    // Write port arbitration: a host preload displaces a same-cycle MemWr.
    always_comb begin
        wr_en_d   = we_i;
        wr_addr_d = addr_i;
        wr_data_d = wdata_i;
        if (load_en_i) begin
            wr_en_d   = 1'b1;
            wr_addr_d = load_addr_i;
            wr_data_d = load_data_i;
        end
    end

    // Array write; deliberately outside the reset domain.
    always_ff @(posedge clock) begin
        if (wr_en_d) begin
            mem_q[wr_addr_d] <= wr_data_d;
        end
    end

    // Registered read word; a same-address write in this edge returns old data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lab_dp.sv
// Datapath of the 8-bit accumulator CPU: PC, IR, accumulator A, the add/sub
// ALU and the program/data RAM. Executes one control word per clock and
// reports opcode and accumulator status back to the control unit.
module lab_dp
    import lab_pkg::*;
#(
    parameter int DW = lab_pkg::DW,
    parameter int AW = lab_pkg::AW
) (
    input  logic     clock,
    input  logic     reset,
    lab_dp_if.slave  dp_if
);

    logic [AW-1:0] pc_q,  pc_d;
    logic [DW-1:0] ir_q,  ir_d;
    logic [DW-1:0] a_q,   a_d;

    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] ram_addr;
    logic [AW-1:0] ir_addr;
    logic [AW-1:0] pc_inc;
    logic [DW-1:0] alu_r;

    // Modulo-2^DW add or subtract; no carry or overflow is kept.
    function automatic logic [DW-1:0] alu_f(
        input logic [DW-1:0] a,
        input logic [DW-1:0] m,
        input logic          sub
    );
        return sub ? (a - m) : (a + m);
    endfunction

    assign ir_addr  = ir_q[AW-1:0];
    assign pc_inc   = pc_q + 1'b1;          // wraps 2^AW-1 -> 0
    assign ram_addr = dp_if.Meminst ? ir_addr : pc_q;
    assign alu_r    = alu_f(a_q, mem_rdata, dp_if.Sub);

    lab_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clock       (clock),
        .reset       (reset),
        .addr_i      (ram_addr),
        .wdata_i     (a_q),
        .we_i        (dp_if.MemWr),
        .load_en_i   (dp_if.load_en),
        .load_addr_i (dp_if.load_addr),
        .load_data_i (dp_if.load_data),
        .rdata_o     (mem_rdata)
    );

    // Next-state selection for PC, IR and A; all sources are pre-edge values.
    always_comb begin
        pc_d = pc_q;
        ir_d = ir_q;
        a_d  = a_q;

        if (dp_if.PCload) begin
            pc_d = dp_if.JMPmux ? ir_addr : pc_inc;
        end

        if (dp_if.IRload) begin
            ir_d = mem_rdata;
        end

        if (dp_if.Aload) begin
            unique case (asel_e'(dp_if.Asel))
                ASEL_ALU:  a_d = alu_r;
                ASEL_SW:   a_d = dp_if.switches;
                ASEL_MEM:  a_d = mem_rdata;
                ASEL_ZERO: a_d = '0;
                default:   a_d = '0;
            endcase
        end
    end

    // Architectural registers, cleared immediately when reset asserts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
            ir_q <= '0;
            a_q  <= '0;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
            a_q  <= a_d;
        end
    end

    // Status is taken from the A register, not from the ALU result.
    assign dp_if.IR     = ir_q[DW-1:DW-3];
    assign dp_if.Aeq0   = (a_q == '0);
    assign dp_if.Apos   = ~a_q[DW-1];
    assign dp_if.A_out  = a_q;
    assign dp_if.PC_out = pc_q;

endmodule

// File: tb/tb_lab_dp.sv
// Directed bench for lab_dp: each control word is applied for one clock and
// outputs are sampled 1 time unit after the rising edge.
module tb_lab_dp;
    import lab_pkg::*;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    lab_dp_if #(.DW(8), .AW(5)) bus ();

    lab_dp #(.DW(8), .AW(5)) dut (
        .clock (clock),
        .reset (reset),
        .dp_if (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.IRload    = 1'b0;
        bus.JMPmux    = 1'b0;
        bus.PCload    = 1'b0;
        bus.Meminst   = 1'b0;
        bus.MemWr     = 1'b0;
        bus.Asel      = 2'b00;
        bus.Aload     = 1'b0;
        bus.Sub       = 1'b0;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
    endtask

    // One control word for one clock, then back to idle.
    task automatic op(input logic irl, input logic pcl, input logic jmp,
                      input logic mi, input logic mw, input logic [1:0] asel,
                      input logic al, input logic sub);
        bus.IRload  = irl;
        bus.PCload  = pcl;
        bus.JMPmux  = jmp;
        bus.Meminst = mi;
        bus.MemWr   = mw;
        bus.Asel    = asel;
        bus.Aload   = al;
        bus.Sub     = sub;
        tick();
        idle();
    endtask

    task automatic preload(input logic [4:0] addr, input logic [7:0] data);
        bus.load_en   = 1'b1;
        bus.load_addr = addr;
        bus.load_data = data;
        tick();
        idle();
    endtask

    task automatic set_a(input logic [7:0] v);
        bus.switches = v;
        op(0, 0, 0, 0, 0, ASEL_SW, 1, 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        bus.switches = '0;
        idle();

        // Reset held low while the program image is preloaded
        preload(5'd0,  8'h3F);
        preload(5'd5,  8'h20);
        preload(5'd1,  8'h29);   // STORE 9
        preload(5'd9,  8'h55);
        preload(5'd2,  8'hB7);   // JZ 23
        preload(5'd23, 8'hBF);   // JZ 31
        chk("rst_low_pc", bus.PC_out, 0);
        reset = 1'b1;
        #1;
        chk("rst_pc",   bus.PC_out, 0);
        chk("rst_a",    bus.A_out,  0);
        chk("rst_aeq0", bus.Aeq0,   1);
        chk("rst_apos", bus.Apos,   1);
        chk("rst_ir",   bus.IR,     0);
        op(0, 0, 0, 0, 0, ASEL_ALU, 0, 0);          // M <= mem[0]
        op(0, 0, 0, 0, 0, ASEL_MEM, 1, 0);          // A <= M
        chk("mem0_kept", bus.A_out, 8'h3F);
        chk("mem0_aeq0", bus.Aeq0,  0);

        // Fetch of ADD 5 at PC 0
        preload(5'd0, 8'h45);
        op(0, 0, 0, 0, 0, ASEL_ALU, 0, 0);
        op(1, 1, 0, 0, 0, ASEL_ALU, 0, 0);
        chk("fetch_ir", bus.IR,     3'b010);
        chk("fetch_pc", bus.PC_out, 1);

        // ALU wrap both directions with mem[5]=20
        set_a(8'hF0);
        op(0, 0, 0, 1, 0, ASEL_ALU, 0, 0);
        op(0, 0, 0, 1, 0, ASEL_ALU, 1, 0);
        chk("add_wrap", bus.A_out, 8'h10);
        op(0, 0, 0, 1, 0, ASEL_ALU, 1, 1);
        chk("sub_wrap", bus.A_out, 8'hF0);
        chk("sub_apos", bus.Apos,  0);
        chk("sub_aeq0", bus.Aeq0,  0);

        // Store to 9 (read-during-write returns old 55), clear, load back
        op(0, 0, 0, 0, 0, ASEL_ALU, 0, 0);
        op(1, 1, 0, 0, 0, ASEL_ALU, 0, 0);
        chk("st_ir", bus.IR,     3'b001);
        chk("st_pc", bus.PC_out, 2);
        set_a(8'h7A);
        op(0, 0, 0, 1, 1, ASEL_ALU, 0, 0);
        op(0, 0, 0, 1, 0, ASEL_MEM, 1, 0);
        chk("rdw_old", bus.A_out, 8'h55);
        op(0, 0, 0, 0, 0, ASEL_ZERO, 1, 0);
        chk("clr_a",    bus.A_out, 0);
        chk("clr_aeq0", bus.Aeq0,  1);
        op(0, 0, 0, 1, 0, ASEL_ALU, 0, 0);
        op(0, 0, 0, 1, 0, ASEL_MEM, 1, 0);
        chk("ld_back", bus.A_out, 8'h7A);

        // Jumps: to 23, simultaneous IRload+jump uses old IR, then 31 and wrap
        op(0, 0, 0, 0, 0, ASEL_ALU, 0, 0);
        op(1, 0, 0, 0, 0, ASEL_ALU, 0, 0);
        chk("jz_ir", bus.IR, 3'b101);
        op(0, 1, 1, 0, 0, ASEL_ALU, 0, 0);
        chk("jmp23", bus.PC_out, 23);
        op(0, 0, 0, 0, 0, ASEL_ALU, 0, 0);
        op(1, 1, 1, 0, 0, ASEL_ALU, 0, 0);
        chk("jmp_old_ir", bus.PC_out, 23);
        op(0, 1, 1, 0, 0, ASEL_ALU, 0, 0);
        chk("jmp31", bus.PC_out, 31);
        op(0, 1, 0, 0, 0, ASEL_ALU, 0, 0);
        chk("pc_wrap", bus.PC_out, 0);

        // Preload beats MemWr at the same address
        preload(5'd0, 8'h63);                      // SUB 3
        op(0, 0, 0, 0, 0, ASEL_ALU, 0, 0);
        op(1, 0, 0, 0, 0, ASEL_ALU, 0, 0);
        chk("sub_ir", bus.IR, 3'b011);
        bus.load_en   = 1'b1;
        bus.load_addr = 5'd3;
        bus.load_data = 8'hC3;
        op(0, 0, 0, 1, 1, ASEL_ALU, 0, 0);
        op(0, 0, 0, 1, 0, ASEL_ALU, 0, 0);
        op(0, 0, 0, 1, 0, ASEL_MEM, 1, 0);
        chk("collide", bus.A_out, 8'hC3);
        set_a(8'h81);
        chk("in_a",    bus.A_out, 8'h81);
        chk("in_apos", bus.Apos,  0);
        chk("in_aeq0", bus.Aeq0,  0);

        // Asynchronous reset mid-cycle clears registers and M, not the RAM
        #3;
        reset = 1'b0;
        #1;
        chk("arst_a",  bus.A_out, 0);
        chk("arst_ir", bus.IR,    0);
        chk("arst_aeq0", bus.Aeq0, 1);
        @(posedge clock);
        #2;
        reset = 1'b1;
        op(0, 0, 0, 0, 0, ASEL_MEM, 1, 0);
        chk("arst_m", bus.A_out, 0);
        op(0, 0, 0, 0, 0, ASEL_MEM, 1, 0);
        chk("arst_mem0", bus.A_out, 8'h63);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
